// File: rtl/ahb_gpio_seq.sv
// AHB-Lite GPIO pattern sequencer: queued SZ-bit patterns are played on SEQ_OUT, each held PRESC+1 cycles.
// Optional macro AHB_GPIO_SEQ_LOOP_EN implements CTRL.LOOP (popped patterns recirculate to the FIFO tail).
module ahb_gpio_seq #(
   parameter int SZ    = 8,
   parameter int DEPTH = 8
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          HSEL,
   input  logic [31:0]   HADDR,
   input  logic [1:0]    HTRANS,
   input  logic          HWRITE,
   input  logic [2:0]    HSIZE,
   input  logic [31:0]   HWDATA,
   input  logic          HREADY,
   output logic          HREADYOUT,
   output logic [31:0]   HRDATA,
   output logic [SZ-1:0] SEQ_OUT,
   output logic [SZ-1:0] SEQ_OE,
   output logic          IRQ
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   // state | meaning
   // IDLE  | waiting for EN with a non-empty FIFO
   // RUN   | holding SEQ_OUT while CNT counts PRESC down to 0
   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t        state_q, state_d;
   logic          dp_valid_q, dp_valid_d;
   logic          dp_write_q, dp_write_d;
   logic [7:0]    dp_addr_q, dp_addr_d;
   logic          en_q, en_d;
   logic [15:0]   presc_q, presc_d;
   logic [15:0]   cnt_q, cnt_d;
   logic [SZ-1:0] oe_q, oe_d;
   logic [2:0]    im_q, im_d;
   logic [2:0]    ris_q, ris_d;
   logic [SZ-1:0] seq_out_q, seq_out_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [SZ-1:0] mem_q [DEPTH];
   logic          mem_we;
   logic [SZ-1:0] mem_wdata;
   logic          wr_en, wr_ctrl, wr_presc, wr_data, wr_oe, wr_im, wr_ris, clr;
   logic          fifo_empty, fifo_full, loop_en, pop, recirc, push_ok;
   logic          set_done, set_empty, set_ovf;
   logic          unused_ok;

   always_comb begin
      dp_valid_d = dp_valid_q;
      dp_write_d = dp_write_q;
      dp_addr_d  = dp_addr_q;
      if (HREADY) begin
         dp_valid_d = HSEL & HTRANS[1];
         dp_write_d = HWRITE;
         dp_addr_d  = HADDR[7:0];
      end
   end

   assign wr_en    = dp_valid_q & dp_write_q & HREADY;
   assign wr_ctrl  = wr_en & (dp_addr_q == 8'h00);
   assign wr_presc = wr_en & (dp_addr_q == 8'h04);
   assign wr_data  = wr_en & (dp_addr_q == 8'h08);
   assign wr_oe    = wr_en & (dp_addr_q == 8'h10);
   assign wr_im    = wr_en & (dp_addr_q == 8'h14);
   assign wr_ris   = wr_en & (dp_addr_q == 8'h18);
   assign clr      = wr_ctrl & HWDATA[2];

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LW'(DEPTH));

`ifdef AHB_GPIO_SEQ_LOOP_EN
   logic loop_q, loop_d;
   always_comb begin
      loop_d = loop_q;
      if (wr_ctrl) loop_d = HWDATA[1];
   end
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) loop_q <= 1'b0;
      else          loop_q <= loop_d;
   end
   assign loop_en = loop_q;
`else
   assign loop_en = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      pop      = 1'b0;
      set_done = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (en_q && !fifo_empty) begin
               pop     = 1'b1;
               cnt_d   = presc_q;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!en_q) begin
               state_d = ST_IDLE;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - 16'd1;
            end else if (!fifo_empty) begin
               pop   = 1'b1;
               cnt_d = presc_q;
            end else begin
               state_d  = ST_IDLE;
               set_done = ~loop_en;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (clr) begin
         pop     = 1'b0;
         state_d = ST_IDLE;
      end
   end

   // A recirculating pop owns the single write port, so a coincident DATA write is dropped as an overflow.
   always_comb begin
      recirc    = pop & loop_en;
      push_ok   = wr_data & ~recirc & (~fifo_full | pop);
      set_ovf   = wr_data & ~push_ok;
      mem_we    = recirc | push_ok;
      mem_wdata = recirc ? mem_q[rd_ptr_q] : HWDATA[SZ-1:0];
      wr_ptr_d  = wr_ptr_q + AW'(mem_we);
      rd_ptr_d  = rd_ptr_q + AW'(pop);
      level_d   = level_q + LW'(push_ok) - LW'(pop & ~recirc);
      seq_out_d = pop ? mem_q[rd_ptr_q] : seq_out_q;
      set_empty = pop & ~recirc & (level_d == '0);
      if (clr) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
         mem_we   = 1'b0;
      end
   end

   always_comb begin
      en_d    = en_q;
      presc_d = presc_q;
      oe_d    = oe_q;
      im_d    = im_q;
      if (wr_ctrl)  en_d    = HWDATA[0];
      if (wr_presc) presc_d = HWDATA[15:0];
      if (wr_oe)    oe_d    = HWDATA[SZ-1:0];
      if (wr_im)    im_d    = HWDATA[2:0];
      ris_d = (ris_q & ~(wr_ris ? HWDATA[2:0] : 3'b000)) | {set_ovf, set_empty, set_done};
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q    <= ST_IDLE;
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_addr_q  <= '0;
         en_q       <= 1'b0;
         presc_q    <= '0;
         cnt_q      <= '0;
         oe_q       <= '0;
         im_q       <= '0;
         ris_q      <= '0;
         seq_out_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
      end else begin
         state_q    <= state_d;
         dp_valid_q <= dp_valid_d;
         dp_write_q <= dp_write_d;
         dp_addr_q  <= dp_addr_d;
         en_q       <= en_d;
         presc_q    <= presc_d;
         cnt_q      <= cnt_d;
         oe_q       <= oe_d;
         im_q       <= im_d;
         ris_q      <= ris_d;
         seq_out_q  <= seq_out_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
      end
   end

   always_ff @(posedge HCLK) begin
      if (mem_we) mem_q[wr_ptr_q] <= mem_wdata;
   end

   always_comb begin
      HRDATA = '0;
      if (dp_valid_q && !dp_write_q) begin
         case (dp_addr_q)
            8'h00: begin
               HRDATA[0] = en_q;
               HRDATA[1] = loop_en;
            end
            8'h04: HRDATA[15:0] = presc_q;
            8'h08: HRDATA = '0;
            8'h0C: begin
               HRDATA[4:0] = 5'(level_q);
               HRDATA[8]   = fifo_full;
               HRDATA[9]   = fifo_empty;
               HRDATA[10]  = (state_q == ST_RUN);
            end
            8'h10: HRDATA[SZ-1:0] = oe_q;
            8'h14: HRDATA[2:0] = im_q;
            8'h18: HRDATA[2:0] = ris_q;
            default: HRDATA = 32'hDEAD_BEEF;
         endcase
      end
   end

   assign HREADYOUT = 1'b1;
   assign SEQ_OUT   = seq_out_q;
   assign SEQ_OE    = oe_q;
   assign IRQ       = |(ris_q & im_q);
   assign unused_ok = &{1'b0, HSIZE, HADDR[31:8], HWDATA};
endmodule

// File: tb/tb_ahb_gpio_seq.sv
// Self-checking bench for ahb_gpio_seq: AHB tasks drive stimulus, a queue model predicts the played sequence.
`timescale 1ns/1ps
module tb_ahb_gpio_seq;
   localparam int SZ    = 8;
   localparam int DEPTH = 8;

   logic          HCLK = 1'b0;
   logic          HRESETn = 1'b0;
   logic          HSEL = 1'b0;
   logic [31:0]   HADDR = '0;
   logic [1:0]    HTRANS = '0;
   logic          HWRITE = 1'b0;
   logic [2:0]    HSIZE = 3'b010;
   logic [31:0]   HWDATA = '0;
   logic          HREADY = 1'b1;
   logic          HREADYOUT;
   logic [31:0]   HRDATA;
   logic [SZ-1:0] SEQ_OUT;
   logic [SZ-1:0] SEQ_OE;
   logic          IRQ;

   int            n_cmp = 0;
   int            n_fail = 0;
   logic [SZ-1:0] model_q[$];
   logic [SZ-1:0] model_out;
   logic [15:0]   model_presc;
   logic          model_ovf;

   ahb_gpio_seq #(.SZ(SZ), .DEPTH(DEPTH)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .SEQ_OUT(SEQ_OUT), .SEQ_OE(SEQ_OE), .IRQ(IRQ)
   );

   always #5 HCLK = ~HCLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // All bus tasks start and end 1 ns after a rising edge.
   task automatic ahb_wr(input logic [7:0] a, input logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
      @(posedge HCLK); #1;
   endtask

   task automatic ahb_wr2(input logic [7:0] a1, input logic [31:0] d1,
                          input logic [7:0] a2, input logic [31:0] d2);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a1};
      @(posedge HCLK); #1;
      HADDR = {24'h0, a2}; HWDATA = d1;
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d2;
      @(posedge HCLK); #1;
   endtask

   task automatic ahb_rd(input logic [7:0] a, output logic [31:0] d);
      HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
      @(posedge HCLK); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      d = HRDATA;
      @(posedge HCLK); #1;
   endtask

   task automatic push(input logic [SZ-1:0] p);
      ahb_wr(8'h08, {24'h0, p});
      if (model_q.size() < DEPTH) model_q.push_back(p);
      else model_ovf = 1'b1;
   endtask

   task automatic fifo_clr();
      ahb_wr(8'h00, 32'h4);
      model_q.delete();
   endtask

   task automatic ris_clr();
      ahb_wr(8'h18, 32'h7);
      model_ovf = 1'b0;
   endtask

   task automatic set_presc(input logic [15:0] p);
      ahb_wr(8'h04, {16'h0, p});
      model_presc = p;
   endtask

   // Enables the sequencer and expects every queued pattern for PRESC+1 cycles, then DONE/EMPTY and idle.
   task automatic run_and_check(input logic [31:0] ctrl, input string name);
      int n, hold;
      logic [31:0] rd;
      n = model_q.size();
      hold = int'(model_presc) + 1;
      ris_clr();
      ahb_wr(8'h00, ctrl);
      for (int k = 1; k <= n * hold; k++) begin
         @(posedge HCLK); #1;
         n_cmp++;
         if (SEQ_OUT !== model_q[(k-1)/hold]) begin
            n_fail++;
            $display("FAIL %s seq_out cycle %0d got %h exp %h", name, k, SEQ_OUT, model_q[(k-1)/hold]);
         end
      end
      model_out = model_q[n-1];
      model_q.delete();
      ahb_rd(8'h0C, rd);
      n_cmp++;
      if (rd !== 32'h200) begin
         n_fail++; $display("FAIL %s status got %h exp %h", name, rd, 32'h200);
      end
      ahb_rd(8'h18, rd);
      n_cmp++;
      if (rd !== 32'h3) begin
         n_fail++; $display("FAIL %s ris got %h exp %h", name, rd, 32'h3);
      end
      n_cmp++;
      if (SEQ_OUT !== model_out) begin
         n_fail++; $display("FAIL %s seq_out_hold got %h exp %h", name, SEQ_OUT, model_out);
      end
      ahb_wr(8'h00, 32'h0);
   endtask

   task automatic test_reset();
      logic [31:0] rd;
      #22;
      n_cmp++;
      if ({HRDATA, HREADYOUT, SEQ_OUT, SEQ_OE, IRQ} !== {32'h0, 1'b1, {SZ{1'b0}}, {SZ{1'b0}}, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_outputs got hrdata=%h rdy=%b out=%h oe=%h irq=%b exp 0/1/0/0/0",
                  HRDATA, HREADYOUT, SEQ_OUT, SEQ_OE, IRQ);
      end
      #1 HRESETn = 1'b1;
      @(posedge HCLK); #1;
      ahb_rd(8'h0C, rd);
      n_cmp++;
      if (rd !== 32'h200) begin n_fail++; $display("FAIL reset_status got %h exp %h", rd, 32'h200); end
      ahb_rd(8'h00, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl got %h exp 0", rd); end
      ahb_rd(8'h18, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ris got %h exp 0", rd); end
   endtask

   task automatic test_regs();
      logic [31:0] rd, v;
      v = $urandom;
      ahb_wr(8'h10, v);
      ahb_rd(8'h10, rd);
      n_cmp++;
      if (rd !== {24'h0, v[7:0]}) begin n_fail++; $display("FAIL oe_read got %h exp %h", rd, {24'h0, v[7:0]}); end
      n_cmp++;
      if (SEQ_OE !== v[7:0]) begin n_fail++; $display("FAIL seq_oe got %h exp %h", SEQ_OE, v[7:0]); end
      v = $urandom;
      ahb_wr(8'h04, v);
      ahb_rd(8'h04, rd);
      n_cmp++;
      if (rd !== {16'h0, v[15:0]}) begin n_fail++; $display("FAIL presc_read got %h exp %h", rd, {16'h0, v[15:0]}); end
      ahb_wr(8'h14, 32'hFFFF_FFFF);
      ahb_rd(8'h14, rd);
      n_cmp++;
      if (rd !== 32'h7) begin n_fail++; $display("FAIL im_read got %h exp 7", rd); end
      ahb_wr(8'h14, 32'h0);
      ahb_rd(8'h1C, rd);
      n_cmp++;
      if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL unmapped_read got %h exp deadbeef", rd); end
   endtask

   task automatic test_sequence();
      fifo_clr();
      set_presc(16'd2);
      push(8'h11); push(8'h22); push(8'h33);
      run_and_check(32'h1, "seq_basic");
   endtask

   task automatic test_overflow();
      logic [31:0] rd;
      fifo_clr();
      ris_clr();
      ahb_wr(8'h14, 32'h0);
      for (int i = 0; i < DEPTH + 1; i++) push(SZ'($urandom));
      ahb_rd(8'h0C, rd);
      n_cmp++;
      if (rd !== 32'h108) begin n_fail++; $display("FAIL ovf_status got %h exp %h", rd, 32'h108); end
      ahb_rd(8'h18, rd);
      n_cmp++;
      if (rd !== {29'h0, model_ovf, 2'b00}) begin
         n_fail++; $display("FAIL ovf_ris got %h exp %h", rd, {29'h0, model_ovf, 2'b00});
      end
      n_cmp++;
      if (IRQ !== 1'b0) begin n_fail++; $display("FAIL ovf_irq_masked got %b exp 0", IRQ); end
      ahb_wr(8'h14, 32'h4);
      n_cmp++;
      if (IRQ !== 1'b1) begin n_fail++; $display("FAIL ovf_irq got %b exp 1", IRQ); end
      ahb_wr(8'h14, 32'h0);
      set_presc(16'd0);
      run_and_check(32'h1, "ovf_drain");
   endtask

   task automatic test_full_pop();
      logic [31:0] rd;
      logic [SZ-1:0] extra, first;
      fifo_clr();
      ris_clr();
      set_presc(16'd20);
      for (int i = 0; i < DEPTH; i++) push(SZ'($urandom));
      extra = SZ'($urandom);
      ahb_wr2(8'h00, 32'h1, 8'h08, {24'h0, extra});
      first = model_q.pop_front();
      model_q.push_back(extra);
      n_cmp++;
      if (SEQ_OUT !== first) begin n_fail++; $display("FAIL fullpop_out got %h exp %h", SEQ_OUT, first); end
      ahb_rd(8'h0C, rd);
      n_cmp++;
      if (rd !== 32'h508) begin n_fail++; $display("FAIL fullpop_status got %h exp %h", rd, 32'h508); end
      ahb_rd(8'h18, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL fullpop_ris got %h exp 0", rd); end
      fifo_clr();
      ahb_rd(8'h0C, rd);
      n_cmp++;
      if (rd !== 32'h200) begin n_fail++; $display("FAIL clr_status got %h exp %h", rd, 32'h200); end
      n_cmp++;
      if (SEQ_OUT !== first) begin n_fail++; $display("FAIL clr_keeps_out got %h exp %h", SEQ_OUT, first); end
   endtask

   task automatic test_en_clear();
      logic [31:0] rd;
      logic [SZ-1:0] second;
      fifo_clr();
      set_presc(16'd0);
      for (int i = 0; i < 4; i++) push(SZ'($urandom));
      ris_clr();
      ahb_wr(8'h00, 32'h1);
      ahb_wr(8'h00, 32'h0);
      void'(model_q.pop_front());
      second = model_q.pop_front();
      n_cmp++;
      if (SEQ_OUT !== second) begin n_fail++; $display("FAIL enclr_out got %h exp %h", SEQ_OUT, second); end
      ahb_rd(8'h0C, rd);
      n_cmp++;
      if (rd !== 32'h002) begin n_fail++; $display("FAIL enclr_status got %h exp %h", rd, 32'h002); end
      ahb_rd(8'h18, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL enclr_ris got %h exp 0", rd); end
      n_cmp++;
      if (SEQ_OUT !== second) begin n_fail++; $display("FAIL enclr_hold got %h exp %h", SEQ_OUT, second); end
      run_and_check(32'h1, "en_resume");
   endtask

   task automatic test_loop();
      logic [31:0] rd;
`ifdef AHB_GPIO_SEQ_LOOP_EN
      fifo_clr();
      set_presc(16'd1);
      push(8'h0A); push(8'h05);
      ris_clr();
      ahb_wr(8'h00, 32'h3);
      for (int k = 1; k <= 24; k++) begin
         @(posedge HCLK); #1;
         n_cmp++;
         if (SEQ_OUT !== model_q[((k-1)/2) % 2]) begin
            n_fail++; $display("FAIL loop_out cycle %0d got %h exp %h", k, SEQ_OUT, model_q[((k-1)/2) % 2]);
         end
      end
      ahb_rd(8'h0C, rd);
      n_cmp++;
      if (rd !== 32'h402) begin n_fail++; $display("FAIL loop_status got %h exp %h", rd, 32'h402); end
      ahb_rd(8'h18, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL loop_ris got %h exp 0", rd); end
      ahb_wr(8'h00, 32'h0);
      fifo_clr();
`else
      fifo_clr();
      ahb_wr(8'h00, 32'h2);
      ahb_rd(8'h00, rd);
      n_cmp++;
      if (rd !== 32'h0) begin n_fail++; $display("FAIL noloop_ctrl got %h exp 0", rd); end
      set_presc(16'd1);
      push(8'h0A); push(8'h05);
      run_and_check(32'h3, "noloop_run");
`endif
   endtask

   task automatic test_random();
      int n;
      for (int it = 0; it < 6; it++) begin
         fifo_clr();
         set_presc(16'($urandom_range(0, 3)));
         n = int'($urandom_range(1, DEPTH));
         for (int i = 0; i < n; i++) push(SZ'($urandom));
         run_and_check(32'h1, "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] rd;
      logic [SZ-1:0] p;
      fifo_clr();
      for (int i = 0; i < DEPTH + 1; i++) push(SZ'($urandom));
      fifo_clr();
      set_presc(16'd0);
      p = SZ'($urandom);
      push(p);
      ahb_rd(8'h18, rd);
      n_cmp++;
      if (rd[2] !== 1'b1) begin n_fail++; $display("FAIL race_pre_ovf got %b exp 1", rd[2]); end
      ahb_wr2(8'h00, 32'h1, 8'h18, 32'h7);
      model_q.delete();
      ahb_rd(8'h18, rd);
      n_cmp++;
      if (rd !== 32'h3) begin n_fail++; $display("FAIL race_ris got %h exp %h", rd, 32'h3); end
      n_cmp++;
      if (SEQ_OUT !== p) begin n_fail++; $display("FAIL race_out got %h exp %h", SEQ_OUT, p); end
      ahb_rd(8'h0C, rd);
      n_cmp++;
      if (rd !== 32'h200) begin n_fail++; $display("FAIL race_status got %h exp %h", rd, 32'h200); end
      ahb_wr(8'h00, 32'h0);
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] rd;
      logic [SZ-1:0] first;
      fifo_clr();
      ahb_wr(8'h14, 32'h7);
      n_cmp++;
      if (IRQ !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq got %b exp 1", IRQ); end
      set_presc(16'd5);
      for (int i = 0; i < 4; i++) push(SZ'($urandom) | SZ'(1));
      first = model_q[0];
      ahb_wr(8'h00, 32'h1);
      @(posedge HCLK); #1;
      @(posedge HCLK); #1;
      n_cmp++;
      if (SEQ_OUT !== first) begin n_fail++; $display("FAIL pre_reset_out got %h exp %h", SEQ_OUT, first); end
      HRESETn = 1'b0;
      #1;
      n_cmp++;
      if ({SEQ_OUT, IRQ, HRDATA, HREADYOUT} !== {{SZ{1'b0}}, 1'b0, 32'h0, 1'b1}) begin
         n_fail++;
         $display("FAIL midreset_outputs got out=%h irq=%b hrdata=%h rdy=%b exp 0/0/0/1",
                  SEQ_OUT, IRQ, HRDATA, HREADYOUT);
      end
      #2 HRESETn = 1'b1;
      model_q.delete();
      @(posedge HCLK); #1;
      ahb_rd(8'h0C, rd);
      n_cmp++;
      if (rd !== 32'h200) begin n_fail++; $display("FAIL post_reset_status got %h exp %h", rd, 32'h200); end
      ahb_rd(8'h20, rd);
      n_cmp++;
      if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL post_reset_0x20 got %h exp deadbeef", rd); end
      n_cmp++;
      if (SEQ_OUT !== '0) begin n_fail++; $display("FAIL post_reset_out got %h exp 0", SEQ_OUT); end
   endtask

   initial begin
      model_out = '0;
      model_presc = '0;
      model_ovf = 1'b0;
      test_reset();
      test_regs();
      test_sequence();
      test_overflow();
      test_full_pop();
      test_en_clear();
      test_loop();
      test_random();
      test_back_to_back();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/ahb_gpio_seq.md
AHB_GPIO_SEQ -- requirements
Module: ahb_gpio_seq

Interface
REQ-001 The block SHALL have parameter SZ, default 8, giving the pattern width in bits (1..32).
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the pattern FIFO depth (power of two, 2..16).
REQ-003 The block SHALL have HCLK, input, 1 bit: the single clock; all state SHALL be clocked on its rising edge.
REQ-004 The block SHALL have HRESETn, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have the AHB-Lite slave inputs HSEL (1), HADDR (32), HTRANS (2), HWRITE (1), HSIZE (3), HWDATA (32) and HREADY (1).
REQ-006 The block SHALL have the AHB-Lite slave outputs HREADYOUT (1, tied 1) and HRDATA (32).
REQ-007 The block SHALL have SEQ_OUT, output, SZ bits: the current pattern, fed to the GPIO port output register.
REQ-008 The block SHALL have SEQ_OE, output, SZ bits: the OE register contents.
REQ-009 The block SHALL have IRQ, output, 1 bit: |(RIS & IM).

Function
REQ-010 Register map (offset, access) SHALL be:
- 0x00 CTRL RW: bit0 EN, bit1 LOOP, bit2 CLR (write-1 pulse, reads 0).
- 0x04 PRESC RW: 16 bits.
- 0x08 DATA WO: a write pushes HWDATA[SZ-1:0].
- 0x0C STATUS RO: [4:0] level, bit8 full, bit9 empty, bit10 busy.
- 0x10 OE RW: SZ bits.
- 0x14 IM RW: 3 bits.
- 0x18 RIS: read; write-1-to-clear. Bit0 DONE, bit1 EMPTY, bit2 OVF.
- Any other offset SHALL read 0xDEADBEEF.
REQ-011 Address and control SHALL be latched in the address phase when HSEL&HREADY&HTRANS[1]; the write SHALL take effect at the end of the data phase; HRDATA SHALL be valid in the data phase.
REQ-012 The FSM SHALL have states IDLE and RUN, with busy = (state==RUN).
REQ-013 In IDLE, when EN=1 and the FIFO is not empty, the FSM SHALL pop the head into SEQ_OUT, load CNT<=PRESC and go to RUN.
REQ-014 In RUN with CNT!=0, the FSM SHALL decrement CNT.
REQ-015 In RUN with CNT==0 and the FIFO not empty, the FSM SHALL pop the next pattern and reload CNT, so that each pattern is held exactly PRESC+1 cycles.
REQ-016 In RUN with CNT==0 and the FIFO empty, the FSM SHALL go to IDLE and set RIS.DONE.
REQ-017 SEQ_OUT SHALL hold its last value whenever no pop occurs.
REQ-018 Clearing EN in RUN SHALL force IDLE on the next edge, keep SEQ_OUT and the FIFO contents, and SHALL NOT set DONE.
REQ-019 RIS.EMPTY SHALL be set on the cycle in which a pop makes the level 0.
REQ-020 A DATA write while full and with no same-cycle pop SHALL be dropped and SHALL set RIS.OVF.
REQ-021 A DATA write while full and with a same-cycle pop SHALL be accepted, leaving the level at DEPTH.
REQ-022 A CLR write SHALL flush the FIFO (level 0, pointers 0) and force IDLE, and SHALL NOT alter SEQ_OUT.
REQ-023 A CLR write SHALL take priority over a same-cycle pop.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; the level SHALL be log2(DEPTH)+1 bits wide.
REQ-025 When a hardware set and a W1C hit the same RIS bit in the same cycle, the set SHALL win.

Reset
REQ-026 HRESETn low SHALL asynchronously clear all of the following:
- CTRL, PRESC, OE, IM, RIS, CNT and the FIFO pointers and level.
- The FSM, to IDLE.
- SEQ_OUT, SEQ_OE and IRQ, to 0.
REQ-027 HRDATA SHALL be 0 and HREADYOUT SHALL be 1 while HRESETn is low.
REQ-028 Reset asserted mid-sequence SHALL discard all queued patterns.

Configuration
REQ-029 With macro AHB_GPIO_SEQ_LOOP_EN defined, CTRL.LOOP=1 SHALL re-push each popped pattern to the tail in the same cycle, so the level is unchanged and the sequence repeats until EN=0.
REQ-030 With AHB_GPIO_SEQ_LOOP_EN defined, DONE and EMPTY SHALL never be set by pops while in LOOP mode.
REQ-031 Without AHB_GPIO_SEQ_LOOP_EN, CTRL.LOOP SHALL be unimplemented, read 0 and have no effect.

Verification
REQ-032 Test 1: PRESC=2, push 0x11, 0x22, 0x33, EN=1 -> SEQ_OUT shows 0x11, 0x22, 0x33 for exactly 3 cycles each, then DONE=1, EMPTY=1 and busy=0, with SEQ_OUT still 0x33.
REQ-033 Test 2: with DEPTH=8, push 9 patterns while EN=0 -> STATUS.level=8, full=1, RIS.OVF=1, and IRQ=1 when IM=0x4.
REQ-034 Test 3: PRESC=0, EN=1, 4 patterns queued, clear EN after the 2nd pop -> FSM IDLE, level=2, SEQ_OUT equals the 2nd pattern, DONE=0.
REQ-035 Test 4: with AHB_GPIO_SEQ_LOOP_EN, LOOP=1, PRESC=1, patterns 0xA, 0x5 -> SEQ_OUT alternates 0xA, 0x5 every 2 cycles for at least 20 cycles, level stays 2, DONE=0.
REQ-036 Test 5: reset pulsed mid-RUN with level=3 -> SEQ_OUT=0, level=0, IRQ=0 immediately; after release, a read of offset 0x20 returns 0xDEADBEEF.
REQ-037 Test 6: W1C of RIS=0x7 in the same cycle as a final pop -> DONE=1 and EMPTY=1 remain set, OVF=0.
